i2s_tx_out: RTL and testbench

Output serializer directly downstream of the equalizer's gain-weighted summation stage: takes each 24-bit `audio_out` sample, buffers it in a small FIFO, and transmits it as a standard Philips I2S stream (64 SCLK per frame, 32 per channel, MSB first, one-bit delay after LRCLK edge). The block generates SCLK and LRCLK from the system clock, so the design needs no external audio clock.

---
 rtl/i2s_tx_out.sv | 160 ++++++++++++++++
 tb/tb_i2s_tx_out.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_out.sv
// i2s_tx_out: sample FIFO feeding a Philips I2S transmitter clocked from clk.
// Define I2S_TX_MONO_DUP_EN to repeat each sample on the right channel.
module i2s_tx_out #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [23:0]                   sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          i2s_sclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic                          underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t        state;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] lvl_nxt;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_nxt;
  logic [23:0]   shreg;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tick;
  logic          frame_end;

  function automatic logic slot_bit(input logic [5:0] bc,
                                    input logic [23:0] s);
    logic [4:0] p;
    logic [4:0] idx;
    logic       b;
    p   = bc[4:0];
    idx = 5'd24 - p;
    b   = 1'b0;
    if (p >= 5'd1 && p <= 5'd24) b = s[idx];
`ifndef I2S_TX_MONO_DUP_EN
    if (bc[5]) b = 1'b0;
`endif
    return b;
  endfunction

  assign empty     = (fifo_level == '0);
  assign push      = sample_valid && sample_ready;
  assign tick      = (state == RUN) && (div_cnt == DIV_MAX);
  assign frame_end = tick && i2s_sclk && (bit_cnt == 6'd63);
  assign bit_nxt   = bit_cnt + 6'd1;
  assign pop       = !empty && en &&
                     ((state == PRIME) || frame_end);

  always_comb begin
    lvl_nxt = fifo_level;
    unique case ({push, pop})
      2'b10:   lvl_nxt = fifo_level + LW'(1);
      2'b01:   lvl_nxt = fifo_level - LW'(1);
      default: lvl_nxt = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      sample_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level   <= lvl_nxt;
      sample_ready <= (lvl_nxt != FULL_LVL);
    end
  end

  // SDATA/LRCLK move only on the falling SCLK tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          div_cnt   <= '0;
          bit_cnt   <= '0;
          i2s_sclk  <= 1'b0;
          i2s_lrclk <= 1'b0;
          i2s_sdata <= 1'b0;
          if (en) state <= PRIME;
        end
        PRIME: begin
          if (!en) begin
            state <= IDLE;
          end else if (!empty) begin
            shreg     <= mem[rd_ptr];
            bit_cnt   <= '0;
            div_cnt   <= '0;
            i2s_sclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (!tick) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt  <= '0;
            i2s_sclk <= ~i2s_sclk;
            if (i2s_sclk) begin
              bit_cnt   <= bit_nxt;
              i2s_lrclk <= bit_nxt[5];
              i2s_sdata <= slot_bit(bit_nxt, shreg);
              if (frame_end) begin
                if (!en) begin
                  state <= IDLE;
                end else if (empty) begin
                  shreg    <= '0;
                  underrun <= 1'b1;
                end else begin
                  shreg <= mem[rd_ptr];
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_out.sv
// tb_i2s_tx_out: directed bench with an I2S receiver and sample scoreboard.
// Frames are decoded on SCLK rising edges and matched against queued samples.
module tb_i2s_tx_out;

  localparam int CLK_DIV = 2;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 128 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        i2s_sclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mon_idx = 0;
  int mon_frames = 0;
  int ur_cnt = 0;
  logic prev_sclk = 1'b0;
  logic lr_bad = 1'b0;
  logic fbits [64];
  logic [23:0] exp_q [$];
  int t_q [$];

  i2s_tx_out #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fifo_level(fifo_level),
    .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame();
    logic [23:0] e;
    logic [23:0] er;
    logic [23:0] gl;
    logic [23:0] gr;
    logic        pad;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
`ifdef I2S_TX_MONO_DUP_EN
    er = e;
`else
    er = '0;
`endif
    for (int j = 0; j < 24; j++) begin
      gl[23-j] = fbits[1+j];
      gr[23-j] = fbits[33+j];
    end
    pad = fbits[0] | fbits[32];
    for (int j = 25; j < 32; j++) pad = pad | fbits[j] | fbits[j+32];
    chk("left", gl, e);
    chk("right", gr, er);
    chk("pad", pad, 1'b0);
    chk("lrclk", lr_bad, 1'b0);
    t_q.push_back(cyc);
    mon_frames++;
  endtask

  // receiver: one bit per SCLK rise, 64 bits per frame
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_idx   = 0;
      prev_sclk = 1'b0;
      lr_bad    = 1'b0;
    end else begin
      if (underrun) ur_cnt++;
      if (i2s_sclk && !prev_sclk) begin
        fbits[mon_idx] = i2s_sdata;
        if (i2s_lrclk !== (mon_idx >= 32)) lr_bad = 1'b1;
        if (mon_idx == 63) begin
          check_frame();
          mon_idx = 0;
          lr_bad  = 1'b0;
        end else begin
          mon_idx++;
        end
      end
      prev_sclk = i2s_sclk;
    end
  end

  initial begin
    logic [23:0] fill_v [5];
    logic [23:0] more_v [3];
    int n;
    int m_lvl;
    int f0;
    int f1;
    bit found;
    fill_v = '{24'h800001, 24'h7FFFFE, 24'h00FF00, 24'hFFFFFF, 24'h5A5A5A};
    more_v = '{24'h13579B, 24'hECA864, 24'h0F0F0F};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_sclk", i2s_sclk, 1'b0);
    chk("rst_lrclk", i2s_lrclk, 1'b0);
    chk("rst_sdata", i2s_sdata, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_ready", sample_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single sample, latency and LRCLK width
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("prime_sclk", i2s_sclk, 1'b0);
    sample_in = 24'hA5C3F1;
    sample_valid = 1'b1;
    exp_q.push_back(24'hA5C3F1);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("push_level", fifo_level, 3'd1);
    n = 0;
    found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      if (i2s_sdata) begin
        n = k;
        found = 1;
      end
    end
    chk("msb_latency", n, 2 * CLK_DIV + 1);
    found = 0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge clk);
      if (i2s_lrclk) found = 1;
    end
    chk("lr_rise_seen", found, 1'b1);
    en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (i2s_lrclk && n < 2 * FRAME);
    chk("lr_high_clks", n, 32 * 2 * CLK_DIV);
    repeat (20) @(negedge clk);
    chk("idle_sclk", i2s_sclk, 1'b0);
    chk("idle_level", fifo_level, 3'd0);
    chk("frames_single", mon_frames, 1);
    chk("underrun_none", ur_cnt, 0);

    // reset in the middle of a frame
    en = 1'b1;
    sample_in = 24'h123456;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (mon_idx == 10) found = 1;
    end
    chk("mid_frame_reached", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", i2s_sclk, 1'b0);
    chk("mid_rst_lrclk", i2s_lrclk, 1'b0);
    chk("mid_rst_sdata", i2s_sdata, 1'b0);
    chk("mid_rst_level", fifo_level, 3'd0);
    chk("mid_rst_ready", sample_ready, 1'b1);
    exp_q.delete();
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fill with transmitter disabled
    m_lvl = 0;
    for (int k = 0; k < 5; k++) begin
      sample_in = fill_v[k];
      sample_valid = 1'b1;
      chk("fill_ready", sample_ready, m_lvl < DEPTH);
      if (m_lvl < DEPTH) begin
        exp_q.push_back(fill_v[k]);
        m_lvl++;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("fill_level", fifo_level, m_lvl);
    chk("fill_ready_full", sample_ready, 1'b0);
    t_q.delete();
    f0 = mon_frames;
    en = 1'b1;

    // drain to underrun
    found = 0;
    for (int k = 0; k < 6 * FRAME && !found; k++) begin
      @(negedge clk);
      if (underrun) found = 1;
    end
    chk("underrun_seen", found, 1'b1);
    chk("frames_fill", mon_frames - f0, 4);
    if (t_q.size() >= 4)
      for (int i = 0; i < 3; i++)
        chk("frame_spacing", t_q[i+1] - t_q[i], FRAME);
    exp_q.push_back(24'h0);
    @(negedge clk);
    chk("underrun_width", underrun, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sample_in = more_v[k];
      sample_valid = 1'b1;
      exp_q.push_back(more_v[k]);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    f1 = mon_frames;

    // disable part-way through the frame after the underrun frame
    found = 0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      @(negedge clk);
      if (mon_frames == f1 + 1 && mon_idx == 41) found = 1;
    end
    chk("disable_point", found, 1'b1);
    en = 1'b0;
    found = 0;
    for (int k = 0; k < FRAME && !found; k++) begin
      @(negedge clk);
      if (mon_frames == f1 + 2) found = 1;
    end
    chk("frame_completed", found, 1'b1);
    repeat (50) @(negedge clk);
    chk("dis_sclk", i2s_sclk, 1'b0);
    chk("dis_lrclk", i2s_lrclk, 1'b0);
    chk("dis_level", fifo_level, 3'd2);
    chk("dis_frames", mon_frames, f1 + 2);
    chk("dis_underruns", ur_cnt, 1);

    // re-enable plays the retained samples
    en = 1'b1;
    found = 0;
    for (int k = 0; k < 4 * FRAME && !found; k++) begin
      @(negedge clk);
      if (mon_frames == f1 + 4) found = 1;
    end
    chk("resume_frames", found, 1'b1);
    en = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("end_level", fifo_level, 3'd0);
    chk("end_sclk", i2s_sclk, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
